// File: rtl/rr_mux_arbiter.sv
// rtl/rr_mux_arbiter.sv - four-requester round-robin arbiter driving a shared W-bit mux
// Grant, index and hold count are registered; the data mux selects from the registered index.
module rr_mux_arbiter #(
  parameter int W        = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [3:0]   req,
  input  logic [W-1:0] d0,
  input  logic [W-1:0] d1,
  input  logic [W-1:0] d2,
  input  logic [W-1:0] d3,
  output logic [3:0]   gnt,
  output logic [1:0]   gnt_idx,
  output logic [W-1:0] o1,
  output logic         out_vld
);

  localparam logic [3:0] HOLD_MAX = 4'(MAX_HOLD);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t     state_q, state_d;
  logic [1:0] ptr_q, ptr_d;
  logic [1:0] idx_q, idx_d;
  logic [3:0] hold_q, hold_d;
  logic [3:0] gnt_q, gnt_d;
  logic [1:0] win;
  logic       any_req;
  logic       others;
  logic [W-1:0] mux_lo, mux_hi, mux_out;

  function automatic logic [3:0] dec2to4(input logic [1:0] s);
    dec2to4 = 4'b0001 << s;
  endfunction

  function automatic logic [W-1:0] mux2(input logic [W-1:0] a, input logic [W-1:0] b,
                                        input logic s);
    mux2 = s ? b : a;
  endfunction

  // First requester at or after p (mod 4); scanned backwards so the nearest one wins.
  function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] p);
    logic [1:0] n;
    pick = p;
    for (int i = 3; i >= 0; i--) begin
      n = p + 2'(i);
      if (r[n]) pick = n;
    end
  endfunction

  always_comb begin
    win     = pick(req, ptr_q);
    any_req = |req;
    others  = |(req & ~dec2to4(idx_q));
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    hold_d  = hold_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d = GRANT;
          idx_d   = win;
          hold_d  = 4'd1;
          ptr_d   = win + 2'd1;
        end
      end
      GRANT: begin
        if (!req[idx_q]) begin
          if (any_req) begin
            idx_d  = win;
            hold_d = 4'd1;
            ptr_d  = win + 2'd1;
          end else begin
            state_d = IDLE;
            hold_d  = 4'd0;
          end
        end else if (hold_q >= HOLD_MAX) begin
          // ptr already points past the grantee, so win is another requester here
          if (others) begin
            idx_d  = win;
            hold_d = 4'd1;
            ptr_d  = win + 2'd1;
          end
        end else begin
          hold_d = hold_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    gnt_d = (state_d == GRANT) ? dec2to4(idx_d) : 4'b0000;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= 2'd0;
      idx_q   <= 2'd0;
      hold_q  <= 4'd0;
      gnt_q   <= 4'b0000;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      hold_q  <= hold_d;
      gnt_q   <= gnt_d;
    end
  end

  always_comb begin
    mux_lo  = mux2(d0, d1, idx_q[0]);
    mux_hi  = mux2(d2, d3, idx_q[0]);
    mux_out = mux2(mux_lo, mux_hi, idx_q[1]);
  end

  assign gnt     = gnt_q;
  assign gnt_idx = idx_q;
  assign out_vld = (state_q == GRANT);
  assign o1      = out_vld ? mux_out : '0;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// tb/tb_rr_mux_arbiter.sv - scoreboard bench for rr_mux_arbiter with a queue-based reference model
module tb_rr_mux_arbiter;
  localparam int W = 8;
  localparam int MAX_HOLD = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [3:0]   req = 4'b0000;
  logic [W-1:0] d0 = '0, d1 = '0, d2 = '0, d3 = '0;
  logic [3:0]   gnt;
  logic [1:0]   gnt_idx;
  logic [W-1:0] o1;
  logic         out_vld;

  rr_mux_arbiter #(.W(W), .MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .rst(rst), .req(req),
    .d0(d0), .d1(d1), .d2(d2), .d3(d3),
    .gnt(gnt), .gnt_idx(gnt_idx), .o1(o1), .out_vld(out_vld)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]   gnt;
    logic [1:0]   idx;
    logic [W-1:0] o1;
    logic         vld;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;

  // Reference model: owner is -1 when idle.
  int         m_owner;
  int         m_ptr;
  int         m_hold;
  logic [3:0] prev_req;

  task automatic m_reset();
    m_owner  = -1;
    m_ptr    = 0;
    m_hold   = 0;
    prev_req = 4'b0000;
  endtask

  task automatic m_step(input logic [3:0] r);
    int win;
    int others;
    win = -1;
    for (int k = 0; k < 4; k++)
      if (win < 0 && r[(m_ptr + k) % 4]) win = (m_ptr + k) % 4;
    others = (m_owner >= 0) ? int'((r & ~(4'b0001 << m_owner)) != 0) : 0;
    if (m_owner < 0 || !r[m_owner] || (m_hold >= MAX_HOLD && others != 0)) begin
      if (win >= 0) begin
        m_owner = win;
        m_hold  = 1;
        m_ptr   = (win + 1) % 4;
      end else begin
        m_owner = -1;
        m_hold  = 0;
      end
    end else if (m_hold < MAX_HOLD) begin
      m_hold = m_hold + 1;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
    end
  endtask

  // One clock of stimulus: model catches up with the edge just taken, then new inputs go out.
  task automatic cyc(input logic [3:0] r, input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic [W-1:0] c, input logic [W-1:0] e, input bit pulse);
    exp_t x;
    logic [W-1:0] dv [4];
    @(posedge clk);
    #2;
    m_step(prev_req);
    req = r; d0 = a; d1 = b; d2 = c; d3 = e;
    dv[0] = a; dv[1] = b; dv[2] = c; dv[3] = e;
    x.vld = (m_owner >= 0);
    x.gnt = x.vld ? (4'b0001 << m_owner) : 4'b0000;
    x.idx = x.vld ? 2'(m_owner) : 2'd0;
    x.o1  = x.vld ? dv[m_owner] : '0;
    exp_q.push_back(x);
    prev_req = r;
    if (pulse) begin
      #4;
      req = 4'b0000;
      prev_req = 4'b0000;
    end
  endtask

  task automatic rcyc(input logic [3:0] r);
    cyc(r, W'($urandom), W'($urandom), W'($urandom), W'($urandom), 1'b0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("out_vld", 32'(out_vld), 32'(e.vld));
      check("gnt", 32'(gnt), 32'(e.gnt));
      check("o1", 32'(o1), 32'(e.o1));
      if (e.vld) check("gnt_idx", 32'(gnt_idx), 32'(e.idx));
    end
  end

  initial begin
    logic [3:0] r;
    m_reset();
    #3;
    check("reset_gnt", 32'(gnt), 32'h0);
    check("reset_vld", 32'(out_vld), 32'h0);
    check("reset_o1", 32'(o1), 32'h0);
    check("reset_idx", 32'(gnt_idx), 32'h0);
    #9 rst = 1'b0;

    // Single request to 2 with known data
    cyc(4'b0100, 8'h11, 8'h22, 8'hA5, 8'h44, 1'b0);
    cyc(4'b0100, 8'h11, 8'h22, 8'hA5, 8'h44, 1'b0);
    cyc(4'b0000, 8'h11, 8'h22, 8'hA5, 8'h44, 1'b0);
    cyc(4'b0000, 8'h11, 8'h22, 8'hA5, 8'h44, 1'b0);

    // All requesting: rotation with MAX_HOLD cycles each
    for (int i = 0; i < 22; i++) rcyc(4'b1111);
    // Lone requester: saturating hold, no rotation
    for (int i = 0; i < 20; i++) rcyc(4'b0010);
    rcyc(4'b0000);
    rcyc(4'b0000);

    // Grantee 0 drops while 3 waits, then everything drops
    rcyc(4'b0001);
    rcyc(4'b1001);
    rcyc(4'b1000);
    rcyc(4'b0000);
    rcyc(4'b0000);

    // Sub-cycle pulse must never be granted
    cyc(4'b0110, 8'h01, 8'h02, 8'h03, 8'h04, 1'b1);
    rcyc(4'b0000);
    rcyc(4'b0000);

    // Randomized traffic, often holding the previous pattern to reach the hold limit
    r = 4'b0000;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) r = 4'($urandom);
      rcyc(r);
    end

    // Async reset mid-grant to 2, then release with 0 and 2 requesting
    rcyc(4'b0100);
    rcyc(4'b0100);
    rcyc(4'b0100);
    #5;
    rst = 1'b1;
    #1;
    check("async_rst_gnt", 32'(gnt), 32'h0);
    check("async_rst_vld", 32'(out_vld), 32'h0);
    check("async_rst_o1", 32'(o1), 32'h0);
    exp_q.delete();
    rst = 1'b0;
    m_reset();
    req = 4'b0101;
    prev_req = 4'b0101;
    rcyc(4'b0101);
    rcyc(4'b0101);
    #3;
    check("post_rst_first_idx", 32'(gnt_idx), 32'h0);
    rcyc(4'b0000);
    rcyc(4'b0000);
    @(posedge clk);
    #4;
    m_step(prev_req);
    check("final_vld", 32'(out_vld), 32'(m_owner >= 0));

    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end
endmodule

// File: doc/rr_mux_arbiter.md
Name: rr_mux_arbiter

Overview:
- Four-requester round-robin arbiter that shares one W-bit data path (a 4:1 mux built from the team's 2:1 MUX/2-4 decoder primitives) between requesters.
- Registered one-hot grant (decoded from a 2-bit index) drives the mux select, so only the granted requester's data reaches the shared output.
- Includes a hold counter so one requester cannot monopolise the path beyond MAX_HOLD cycles while others wait.

Parameters:
- W, 8, data width of each requester input and of the shared output.
- MAX_HOLD, 4, max consecutive grant cycles per requester when another request is pending. Legal range is 1..15.

Ports:
- clk  input  1  single system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  4  request lines; bit n is requester n.
- d0   input  W  requester 0 data.
- d1   input  W  requester 1 data.
- d2   input  W  requester 2 data.
- d3   input  W  requester 3 data.
- gnt  output 4  registered one-hot grant; all zeros when idle.
- gnt_idx  output 2  registered binary index of the current grantee.
- o1   output W  shared mux output, d[gnt_idx] while out_vld=1, else 0.
- out_vld  output 1  high while a grant is active.

Behaviour:
- Clock, reset and polarity: one clock (clk); reset rst is asynchronous and active-high.
- State encoding: two states, IDLE and GRANT, plus the following registers:
  - ptr[1:0]: round-robin start point.
  - gnt_idx[1:0]: current grantee index.
  - hold_cnt[3:0]: consecutive grant cycles for the current grantee.
- Reset: asserting rst forces the following values immediately, regardless of clk:
  - state = IDLE, ptr = 0, gnt_idx = 0, hold_cnt = 0;
  - gnt = 4'b0000, out_vld = 0, o1 = 0.
  - Reset mid-grant drops the grant with no completion cycle.
- Winner selection: the first n with req[n]=1, searching ptr, ptr+1, ptr+2, ptr+3 mod 4. Selection is combinational from sampled req.
- IDLE: when req != 0 at a rising edge, the next state is GRANT with:
  - gnt_idx = winner, gnt = one-hot(winner);
  - hold_cnt = 1, ptr = winner+1 mod 4.
  - Latency: the grant is visible in the cycle after the first sampled request, i.e. exactly one clk.
- GRANT, evaluated each rising edge:
  - req[gnt_idx]=0, other req pending: switch to the new winner in the same edge (no idle bubble), with hold_cnt = 1 and ptr updated.
  - req[gnt_idx]=0, no req pending: go to IDLE with gnt = 0 and out_vld = 0.
  - req[gnt_idx]=1, hold_cnt == MAX_HOLD, another req pending: forced rotation to the winner searched from ptr, which excludes the current grantee because ptr = grantee+1. Set hold_cnt = 1.
  - req[gnt_idx]=1, hold_cnt == MAX_HOLD, no other req: keep the grant; hold_cnt saturates at MAX_HOLD with no wrap.
  - Otherwise: keep the grant and increment hold_cnt.
- Output path:
  - o1 = d[gnt_idx] combinationally when out_vld=1, else all zeros.
  - out_vld = (state == GRANT).
  - gnt always equals one-hot(gnt_idx) in GRANT and 0 in IDLE; never more than one bit is set.
- Simultaneous events:
  - Grantee drop and a new request arriving in the same edge: the new request is eligible immediately.
  - A request that arrives and leaves between edges is never seen and never granted.
- Data width: o1 is exactly W bits, with no sign or extension logic.

Test Plan:
- Reset then req=4'b0100, d2=8'hA5 -> one clk later: gnt=4'b0100, gnt_idx=2, out_vld=1, o1=8'hA5, ptr=3.
- req=4'b1111 held constant, MAX_HOLD=4 -> grants rotate 0,1,2,3,0, each held exactly 4 cycles. o1 tracks d0..d3 in turn, and there are no idle cycles between grants.
- Only req[1]=1 held for 20 cycles -> gnt stays 4'b0010 throughout, hold_cnt saturates at 4, no rotation.
- Grantee 0 drops while req[3]=1 -> next edge: gnt=4'b1000 with no out_vld gap. Then drop all requests -> next edge: gnt=0, out_vld=0, o1=0.
- Assert rst asynchronously mid-cycle during a grant to 2 -> gnt, out_vld and o1 go to 0 immediately, before the next clk. Release with req=4'b0101 -> requester 0 is granted first (ptr reset to 0).
- req pulse shorter than one clk between edges -> no grant issued, out_vld stays 0.
